// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared constants and types for the ALU issue stage
//
// Purpose: RV64I major opcodes handled by the issue stage, the 4-bit ALU op
// encoding ({funct7, funct3} as seen by the ALU), the decoded side-band
// payload layout, and the state type of the 2-entry skid buffer.
// Ports: none (package).
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SLL  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_AND  = 4'h7,
    ALU_SUB  = 4'h8,
    ALU_BEQ  = 4'h9,
    ALU_BNE  = 4'hA,
    ALU_BLT  = 4'hB,
    ALU_BGE  = 4'hC,
    ALU_SRA  = 4'hD,
    ALU_BLTU = 4'hE,
    ALU_BGEU = 4'hF
  } alu_op_e;

  // Everything the ALU needs besides the two operands.
  typedef struct packed {
    logic       funct7;
    logic [2:0] funct3;
    logic [4:0] rd_idx;
    logic       is_branch;
    logic       illegal;
  } issue_meta_t;

  localparam int META_W = $bits(issue_meta_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Branch funct3 to ALU compare code; 010/011 are not branches and map to ADD
  // (callers flag them illegal separately).
  function automatic logic [3:0] branch_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_BEQ;
      3'b001:  op = ALU_BNE;
      3'b100:  op = ALU_BLT;
      3'b101:  op = ALU_BGE;
      3'b110:  op = ALU_BLTU;
      3'b111:  op = ALU_BGEU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// rtl/alu_issue_skid.sv - generic 2-entry skid buffer with valid/ready
//
// Purpose: registers a W-bit payload between two valid/ready interfaces in
// strict FIFO order. in_ready depends only on registered state (and reset),
// never on out_ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (head entry)
module alu_issue_skid
  import alu_issue_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] head_q, tail_q;
  logic         push, pop;
  logic         load_head_in, load_head_tail, load_tail;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    // Held low through reset so nothing is accepted while rst_n is asserted.
    in_ready       = rst_n && (state_q != SKID_FULL);
    out_valid      = (state_q != SKID_EMPTY);
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d      = SKID_ONE;
          load_head_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_d   = SKID_FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // No push possible here: in_ready is low.
        if (pop) begin
          state_d        = SKID_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_head_in) begin
        head_q <= in_data;
      end else if (load_head_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= in_data;
      end
    end
  end

  assign out_data = head_q;

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - RV64I OP/OP-IMM/BRANCH decode and issue to the ALU
//
// Purpose: decodes an instruction plus its register values into ALU operands
// and a 4-bit op code {funct7, funct3}, then registers the result through a
// 2-entry skid buffer. Undecodable instructions are forwarded with
// out_illegal set and zeroed operands. Build option: ALU_ISSUE_BRANCH_EN
// enables BRANCH decode; without it branches are reported illegal.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake
//   in_instr, in_rs1_val, in_rs2_val  instruction word and register values
//   out_valid/out_ready            downstream handshake
//   out_rs1, out_rs2               ALU operands (rs2 value or immediate)
//   out_funct3, out_funct7         ALU op code
//   out_rd_idx                     writeback index (0 for branch/illegal)
//   out_is_branch, out_illegal     branch marker, decode failure marker
module alu_op_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [2:0]      out_funct3,
  output logic            out_funct7,
  output logic [4:0]      out_rd_idx,
  output logic            out_is_branch,
  output logic            out_illegal
);

  localparam int PW = 2 * XLEN + META_W;

  function automatic logic [PW-1:0] decode(input logic [31:0]     instr,
                                           input logic [XLEN-1:0] rs1_val,
                                           input logic [XLEN-1:0] rs2_val);
    issue_meta_t     meta;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            legal;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    opc         = instr[6:0];
    f3          = instr[14:12];
    f7          = instr[31:25];
    meta        = '0;
    meta.funct3 = f3;
    meta.rd_idx = instr[11:7];
    a           = rs1_val;
    b           = rs2_val;
    legal       = 1'b0;
    case (opc)
      OPC_OP: begin
        legal       = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        meta.funct7 = instr[30];
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b001: begin
            legal = (instr[31:26] == 6'b000000);
            b     = {{(XLEN-6){1'b0}}, instr[25:20]};
          end
          3'b101: begin
            legal       = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
            b           = {{(XLEN-6){1'b0}}, instr[25:20]};
            meta.funct7 = instr[30];
          end
          default: begin
            // funct7 stays 0: imm bit 30 must not turn ADDI into SUB.
            legal = 1'b1;
            b     = {{(XLEN-12){instr[31]}}, instr[31:20]};
          end
        endcase
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        legal                     = (f3 != 3'b010) && (f3 != 3'b011);
        {meta.funct7, meta.funct3} = branch_op(f3);
        meta.rd_idx               = 5'd0;
        meta.is_branch            = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      meta         = '0;
      meta.illegal = 1'b1;
      a            = '0;
      b            = '0;
    end
    return {a, b, meta};
  endfunction

  // Register indices are resolved before this stage; the rs1 field is not needed.
  logic unused_rs1_field;
  assign unused_rs1_field = ^in_instr[19:15];

  logic [PW-1:0] dec_payload;
  logic [PW-1:0] out_payload;
  issue_meta_t   out_meta;

  assign dec_payload = decode(in_instr, in_rs1_val, in_rs2_val);

  alu_issue_skid #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_rs1, out_rs2, out_meta} = out_payload;
  assign out_funct7    = out_meta.funct7;
  assign out_funct3    = out_meta.funct3;
  assign out_rd_idx    = out_meta.rd_idx;
  assign out_is_branch = out_meta.is_branch;
  assign out_illegal   = out_meta.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - directed self-checking bench for alu_op_issue
module tb_alu_op_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rs1;
  logic [63:0] out_rs2;
  logic [2:0]  out_funct3;
  logic        out_funct7;
  logic [4:0]  out_rd_idx;
  logic        out_is_branch;
  logic        out_illegal;

  int n_cmp;
  int n_fail;

  typedef struct {
    string        name;
    logic [31:0]  instr;
    logic [63:0]  rs1;
    logic [63:0]  rs2;
    logic [139:0] exp;
  } vec_t;

  alu_op_issue #(.XLEN(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs1_val    (in_rs1_val),
    .in_rs2_val    (in_rs2_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_rd_idx    (out_rd_idx),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle: {valid, rs1, rs2, funct7, funct3, rd, is_branch, illegal}
  function automatic logic [139:0] e_ok(input logic [63:0] a, input logic [63:0] b,
                                        input logic f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic br);
    return {1'b1, a, b, f7, f3, rd, br, 1'b0};
  endfunction

  function automatic logic [139:0] e_ill();
    return {1'b1, 64'd0, 64'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [139:0] got;
    #1;
    got = {out_valid, out_rs1, out_rs2, out_funct7, out_funct3, out_rd_idx, out_is_branch, out_illegal};
    n_cmp++;
    if (got !== 140'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_decode();
    vec_t         v[$];
    logic [139:0] got;
    v.push_back('{"ADD",    32'h002081B3, 64'd1, 64'd2, e_ok(64'd1, 64'd2, 1'b0, 3'd0, 5'd3, 1'b0)});
    v.push_back('{"SUB",    32'h402081B3, 64'd5, 64'd3, e_ok(64'd5, 64'd3, 1'b1, 3'd0, 5'd3, 1'b0)});
    v.push_back('{"MUL",    32'h022081B3, 64'd5, 64'd3, e_ill()});
    v.push_back('{"SLT_F7", 32'h4020A1B3, 64'd5, 64'd3, e_ill()});
    v.push_back('{"SRAI",   32'h40235293, 64'hFFFF_FFFF_FFFF_FFF0, 64'h55,
                  e_ok(64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 1'b1, 3'd5, 5'd5, 1'b0)});
    v.push_back('{"ADDI_M1", 32'hFFF00093, 64'd0, 64'h1234,
                  e_ok(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 5'd1, 1'b0)});
    v.push_back('{"ADDI_B30", 32'h40000093, 64'd9, 64'h1234, e_ok(64'd9, 64'h400, 1'b0, 3'd0, 5'd1, 1'b0)});
    v.push_back('{"SLLI",   32'h00309093, 64'd7, 64'hAA, e_ok(64'd7, 64'd3, 1'b0, 3'd1, 5'd1, 1'b0)});
    v.push_back('{"SLLI_BAD", 32'h40309093, 64'd7, 64'hAA, e_ill()});
    v.push_back('{"SRLI_33", 32'h02135293, 64'h80, 64'hAA, e_ok(64'h80, 64'd33, 1'b0, 3'd5, 5'd5, 1'b0)});
`ifdef ALU_ISSUE_BRANCH_EN
    v.push_back('{"BLTU",   32'h0020E063, 64'd1, 64'd2, e_ok(64'd1, 64'd2, 1'b1, 3'b110, 5'd0, 1'b1)});
    v.push_back('{"BEQ",    32'h00208063, 64'd4, 64'd4, e_ok(64'd4, 64'd4, 1'b1, 3'b001, 5'd0, 1'b1)});
    v.push_back('{"BGE",    32'h0020D063, 64'd4, 64'd6, e_ok(64'd4, 64'd6, 1'b1, 3'b100, 5'd0, 1'b1)});
`else
    v.push_back('{"BLTU",   32'h0020E063, 64'd1, 64'd2, e_ill()});
    v.push_back('{"BEQ",    32'h00208063, 64'd4, 64'd4, e_ill()});
`endif
    v.push_back('{"BR_F3_2", 32'h0020A063, 64'd1, 64'd2, e_ill()});
    v.push_back('{"LOAD",   32'h0000B083, 64'd1, 64'd2, e_ill()});
    out_ready = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      in_valid   = 1'b1;
      in_instr   = v[i].instr;
      in_rs1_val = v[i].rs1;
      in_rs2_val = v[i].rs2;
      tick();
      in_valid = 1'b0;
      got = {out_valid, out_rs1, out_rs2, out_funct7, out_funct3, out_rd_idx, out_is_branch, out_illegal};
      n_cmp++;
      if (got !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", v[i].name, got, v[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready  = 1'b0;
    in_rs2_val = 64'd0;
    in_valid   = 1'b1;
    in_instr   = 32'h002080B3;
    in_rs1_val = 64'h11;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_one: got %b want 1", in_ready);
    end
    in_instr   = 32'h00208133;
    in_rs1_val = 64'h22;
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_full: got %b want 0", in_ready);
    end
    in_instr   = 32'h002081B3;
    in_rs1_val = 64'h33;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_rd_idx !== 5'd1 || out_rs1 !== 64'h11) begin
      n_fail++;
      $display("FAIL bp_head_stable: valid %b rd %0d rs1 %h want 1 1 11", out_valid, out_rd_idx, out_rs1);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_comb_ready: got %b want 0", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_rd_idx !== 5'd2 || out_rs1 !== 64'h22) begin
      n_fail++;
      $display("FAIL bp_second: valid %b rd %0d rs1 %h want 1 2 22", out_valid, out_rd_idx, out_rs1);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drained: valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_instr   = 32'h00208233;
    in_rs1_val = 64'h44;
    tick();
    n_cmp++;
    if (out_rd_idx !== 5'd4 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: rd %0d in_ready %b want 4 1", out_rd_idx, in_ready);
    end
    in_instr   = 32'h002082B3;
    in_rs1_val = 64'h55;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_rd_idx !== 5'd5 || out_rs1 !== 64'h55) begin
      n_fail++;
      $display("FAIL b2b_second: valid %b rd %0d rs1 %h want 1 5 55", out_valid, out_rd_idx, out_rs1);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_instr   = 32'h00208333;
    in_rs1_val = 64'h66;
    tick();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_full: in_ready %b valid %b want 0 1", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_rs1 !== 64'd0 || out_rd_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_async: valid %b in_ready %b rs1 %h rd %0d want 0 0 0 0",
               out_valid, in_ready, out_rs1, out_rd_idx);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_stale: cycle %0d valid %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = 32'd0;
    in_rs1_val = 64'd0;
    in_rs2_val = 64'd0;
    out_ready  = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
